// File: rtl/edsac_mem_pkg.sv
// Shared constants and gate-FSM state type for the EDSAC mercury-tank store.
package edsac_mem_pkg;

  localparam int SHORT_SLOT_BITS = 18;
  localparam int TANK_SLOTS      = 32;

  typedef enum logic [1:0] {
    GATE_IDLE   = 2'd0,
    GATE_ARMED  = 2'd1,
    GATE_ACTIVE = 2'd2
  } gate_state_t;

endpackage

// File: rtl/delay_line_atom.sv
// DEPTH-stage serial delay line: tail enters stage 0, head leaves the last stage.
module delay_line_atom #(
  parameter int DEPTH = 576
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tail,
  output logic o_head
);

  logic [DEPTH-1:0] r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else begin
      r_line <= {r_line[DEPTH-2:0], i_tail};
    end
  end

  assign o_head = r_line[DEPTH-1];

endmodule

// File: rtl/memory_tank_param.sv
// One EDSAC mercury tank: recirculating serial store with position counters,
// optional slot-synchronous gating and registered bus/monitor outputs.
module memory_tank_param
  import edsac_mem_pkg::*;
#(
  parameter int SLOT_BITS = SHORT_SLOT_BITS,
  parameter int SLOTS     = TANK_SLOTS,
  parameter bit SLOT_MODE = 1'b0
) (
  input  logic                         r2_clk,
  input  logic                         r2_rst_n,
  input  logic                         r2_mib,
  input  logic                         r2_t_in,
  input  logic                         r2_t_clr,
  input  logic                         r2_t_out,
  output logic                         r2_mob,
  output logic                         monitor,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic [$clog2(SLOTS)-1:0]     slot_idx,
  output logic                         slot_start
);

  localparam int DEPTH = SLOTS * SLOT_BITS;
  localparam int BW    = $clog2(SLOT_BITS);
  localparam int SW    = $clog2(SLOTS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] HEAD_LAST = BW'(SLOT_BITS - 2);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  logic [BW-1:0] r_bit;
  logic [SW-1:0] r_slot;
  logic          r_mob;
  logic          r_mon;
  gate_state_t   r_gst [3];
  logic [2:0]    r_rearm;

  logic       w_head;
  logic       w_tail;
  logic       w_head_last;
  logic [2:0] w_gate;
  logic [2:0] w_act;
  logic       w_in_eff;
  logic       w_clr_eff;
  logic       w_out_eff;

  // Counters describe the registered output digit, so the head is one position ahead.
  assign w_head_last = (r_bit == HEAD_LAST);
  assign w_gate      = {r2_t_out, r2_t_clr, r2_t_in};

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      r_bit  <= '0;
      r_slot <= '0;
    end else if (r_bit == LAST_BIT) begin
      r_bit  <= '0;
      r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
    end else begin
      r_bit <= r_bit + 1'b1;
    end
  end

  // Gate FSMs (index 0 = in, 1 = clr, 2 = out). ACTIVE spans head digits 0..SLOT_BITS-1
  // of one slot. A request at the slot boundary (or one remembered during ACTIVE) goes
  // straight to ACTIVE, since ARMED would be left on that very edge anyway.
  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      for (int g = 0; g < 3; g++) r_gst[g] <= GATE_IDLE;
      r_rearm <= '0;
    end else begin
      for (int g = 0; g < 3; g++) begin
        case (r_gst[g])
          GATE_IDLE: begin
            if (w_gate[g]) r_gst[g] <= w_head_last ? GATE_ACTIVE : GATE_ARMED;
          end
          GATE_ARMED: begin
            if (w_head_last) r_gst[g] <= GATE_ACTIVE;
          end
          GATE_ACTIVE: begin
            if (w_head_last) begin
              r_gst[g]   <= (r_rearm[g] || w_gate[g]) ? GATE_ACTIVE : GATE_IDLE;
              r_rearm[g] <= 1'b0;
            end else if (w_gate[g]) begin
              r_rearm[g] <= 1'b1;
            end
          end
          default: r_gst[g] <= GATE_IDLE;
        endcase
      end
    end
  end

  assign w_act[0] = (r_gst[0] == GATE_ACTIVE);
  assign w_act[1] = (r_gst[1] == GATE_ACTIVE);
  assign w_act[2] = (r_gst[2] == GATE_ACTIVE);

  assign w_in_eff  = SLOT_MODE ? w_act[0] : r2_t_in;
  assign w_clr_eff = SLOT_MODE ? w_act[1] : r2_t_clr;
  assign w_out_eff = SLOT_MODE ? w_act[2] : r2_t_out;

  // Clear has priority over write; otherwise the head recirculates.
  assign w_tail = w_clr_eff ? 1'b0 : (w_in_eff ? r2_mib : w_head);

  delay_line_atom #(.DEPTH(DEPTH)) u_line (
    .i_clk   (r2_clk),
    .i_rst_n (r2_rst_n),
    .i_tail  (w_tail),
    .o_head  (w_head)
  );

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      r_mob <= 1'b0;
      r_mon <= 1'b0;
    end else begin
      r_mob <= w_out_eff & w_head;
      r_mon <= w_head;
    end
  end

  assign r2_mob     = r_mob;
  assign monitor    = r_mon;
  assign bit_idx    = r_bit;
  assign slot_idx   = r_slot;
  assign slot_start = (r_bit == '0);

endmodule
